// File: rtl/mux_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mux_scan_ctrl
// Description : Upstream sequencer for a 4:1 mux. Steps the select lines
//               {s2,s1} through channels 0..3, samples the mux output on the
//               last edge of each channel slot, and hands the assembled
//               4-bit snapshot downstream over a valid/ready handshake.
//               One start pulse triggers one scan.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   SETTLE_CYC  extra cycles the select is held before y_in is sampled (>=0);
//               each channel slot lasts SETTLE_CYC+1 cycles
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   scan request, honoured only when idle
//   y_in   in   mux output being scanned
//   s1     out  select LSB (sel[0])
//   s2     out  select MSB (sel[1])
//   busy   out  high while a scan is in progress
//   data   out  snapshot; data[i] = y_in sampled while {s2,s1}==i
//   valid  out  data holds a completed scan
//   ready  in   downstream accepts data when valid&ready
// Configuration
//   MUX_SCAN_CONT_EN  defined: continuous mode, a completed handshake starts
//                     the next scan on the same edge (start needed only once
//                     after reset). Undefined: single-shot, every scan needs
//                     its own start pulse.
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
);

  // Counter is at least one bit wide so SETTLE_CYC=0 still elaborates.
  localparam int               CNT_W    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYC);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_scan = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

`ifdef MUX_SCAN_CONT_EN
  localparam logic c_cont_en = 1'b1;
`else
  localparam logic c_cont_en = 1'b0;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_shadow;
  logic [3:0]       r_data;
  logic             r_valid;
  logic             r_busy;

  logic [1:0]       w_sel_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_shadow_nxt;
  logic [3:0]       w_data_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;

  // Last edge of the current channel slot.
  logic             w_slot_end;
  logic             w_last_chan;
  logic             w_handshake;

  assign w_slot_end  = (r_cnt == '0);
  assign w_last_chan = (r_sel == 2'd3);
  assign w_handshake = r_valid & ready;

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nxt = c_st_scan;
        end
      end
      c_st_scan: begin
        if (w_slot_end && w_last_chan) begin
          w_state_nxt = c_st_done;
        end
      end
      c_st_done: begin
        if (w_handshake) begin
          w_state_nxt = c_cont_en ? c_st_scan : c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output / datapath next values. Every output is registered below, so the
  // select lines only move on channel boundaries and never glitch.
  //--------------------------------------------------------------------------
  always_comb begin
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    w_busy_nxt   = r_busy;

    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_sel_nxt  = 2'd0;
          w_cnt_nxt  = c_settle;
          w_busy_nxt = 1'b1;
        end
      end

      c_st_scan: begin
        if (!w_slot_end) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_shadow_nxt[r_sel] = y_in;
          if (!w_last_chan) begin
            w_sel_nxt = r_sel + 2'd1;
            w_cnt_nxt = c_settle;
          end else begin
            // Channel 3 is taken straight from y_in since the shadow bit is
            // only being written on this same edge.
            w_data_nxt  = {y_in, r_shadow[2:0]};
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_sel_nxt   = 2'd0;
          end
        end
      end

      c_st_done: begin
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          if (c_cont_en) begin
            w_sel_nxt  = 2'd0;
            w_cnt_nxt  = c_settle;
            w_busy_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_sel_nxt   = 2'd0;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 2'd0;
      r_cnt    <= '0;
      r_shadow <= 4'd0;
      r_data   <= 4'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign s1    = r_sel[0];
  assign s2    = r_sel[1];
  assign busy  = r_busy;
  assign data  = r_data;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mux_scan_ctrl
// Description : Directed self-checking bench for mux_scan_ctrl. Two instances
//               run side by side: dut (SETTLE_CYC=1) and dut0 (SETTLE_CYC=0).
//               Each is fed by its own behavioural 4:1 mux over a shared
//               channel vector. With MUX_SCAN_CONT_EN defined the continuous
//               mode sequence is run instead of the single-shot sequence.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;

  // Mux inputs written a,b,c,d MSB-first: a drives channel 3, d channel 0,
  // so a completed snapshot reads back as the vector {a,b,c,d}.
  logic [3:0] ch;

  logic       start, ready, y;
  logic       s1, s2, busy, valid;
  logic [3:0] data;

  logic       start0, ready0, y0;
  logic       s1_0, s2_0, busy0, valid0;
  logic [3:0] data0;

  int n_tests;
  int n_fail;

  assign y  = ch[{s2, s1}];
  assign y0 = ch[{s2_0, s1_0}];

  mux_scan_ctrl #(.SETTLE_CYC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y_in  (y),
    .s1    (s1),
    .s2    (s2),
    .busy  (busy),
    .data  (data),
    .valid (valid),
    .ready (ready)
  );

  mux_scan_ctrl #(.SETTLE_CYC(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start0),
    .y_in  (y0),
    .s1    (s1_0),
    .s2    (s2_0),
    .busy  (busy0),
    .data  (data0),
    .valid (valid0),
    .ready (ready0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int vcnt;
    int bcnt;
    int rise [4];
    int rise0[4];
    int nr;
    int nr0;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    ready   = 1'b0;
    start0  = 1'b0;
    ready0  = 1'b0;
    ch      = 4'b0101;

    // Reset state
    tick(2);
    check("rst_busy",  8'(busy),     8'd0);
    check("rst_valid", 8'(valid),    8'd0);
    check("rst_sel",   8'({s2, s1}), 8'd0);
    check("rst_data",  8'(data),     8'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_no_start", 8'(busy), 8'd0);

`ifndef MUX_SCAN_CONT_EN
    // 1. a..d = 0,1,0,1, ready=1: select sequence and latency.
    ready = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t1_busy", 8'(busy), 8'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick(1);
      check($sformatf("t1_sel%0d", k), 8'({s2, s1}), 8'(k / 2));
      check($sformatf("t1_nv%0d", k),  8'(valid),    8'd0);
    end
    tick(1);
    check("t1_valid", 8'(valid),    8'd1);
    check("t1_data",  8'(data),     8'h05);
    check("t1_busy0", 8'(busy),     8'd0);
    check("t1_sel0",  8'({s2, s1}), 8'd0);
    tick(1);
    check("t1_hs_valid", 8'(valid), 8'd0);
    check("t1_hs_data",  8'(data),  8'h05);
    tick(3);
    check("t1_idle", 8'(busy), 8'd0);

    // 2. ready=0 for 20 cycles: word held stable.
    ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid === 1'b1 && data === 4'b0101) vcnt++;
      tick(1);
    end
    check("t2_stable", 8'(vcnt), 8'd20);
    ready = 1'b1;
    tick(1);
    check("t2_clear", 8'(valid), 8'd0);
    check("t2_data",  8'(data),  8'h05);

    // 3. start pulsed during SCAN and DONE is ignored.
    ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t3_scan_sel", 8'({s2, s1}), 8'd1);
    tick(5);
    check("t3_valid", 8'(valid), 8'd1);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    check("t3_done_hold", 8'(valid), 8'd1);
    check("t3_done_busy", 8'(busy),  8'd0);
    ready = 1'b1;
    tick(1);
    check("t3_hs", 8'(valid), 8'd0);
    vcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (valid === 1'b1) vcnt++;
      if (busy === 1'b1) bcnt++;
    end
    check("t3_no_extra_valid", 8'(vcnt), 8'd0);
    check("t3_no_extra_busy",  8'(bcnt), 8'd0);

    // 4. Reset at cycle 3 of a scan aborts it immediately.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("t4_pre_sel", 8'({s2, s1}), 8'd1);
    rst_n = 1'b0;
    #1;
    check("t4_busy",  8'(busy),     8'd0);
    check("t4_valid", 8'(valid),    8'd0);
    check("t4_sel",   8'({s2, s1}), 8'd0);
    check("t4_data",  8'(data),     8'd0);
    tick(1);
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (valid === 1'b1 || busy === 1'b1) vcnt++;
    end
    check("t4_no_resume", 8'(vcnt), 8'd0);

    // 5. Inputs change between scans.
    ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    check("t5_first", 8'(data), 8'h05);
    ch = 4'b1010;
    tick(4);
    check("t5_first_held", 8'(data),  8'h05);
    check("t5_first_vld",  8'(valid), 8'd1);
    ready = 1'b1;
    tick(1);
    check("t5_hs", 8'(valid), 8'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    check("t5_pre", 8'(valid), 8'd0);
    tick(1);
    check("t5_second_vld",  8'(valid), 8'd1);
    check("t5_second_data", 8'(data),  8'h0a);

    // SETTLE_CYC=0: one cycle per channel, valid after 4 edges.
    ch     = 4'b0110;
    ready0 = 1'b1;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick(1);
      check($sformatf("s0_sel%0d", k), 8'({s2_0, s1_0}), 8'(k));
      check($sformatf("s0_nv%0d", k),  8'(valid0),       8'd0);
    end
    tick(1);
    check("s0_valid", 8'(valid0), 8'd1);
    check("s0_data",  8'(data0),  8'h06);
    tick(1);
    check("s0_hs",   8'(valid0), 8'd0);
    check("s0_idle", 8'(busy0),  8'd0);
`else
    // 6. Continuous mode: back-to-back scans after a single start.
    ready  = 1'b1;
    ready0 = 1'b1;
    start  = 1'b1;
    start0 = 1'b1;
    tick(1);
    start  = 1'b0;
    start0 = 1'b0;
    nr  = 0;
    nr0 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (valid === 1'b1) begin
        if (nr < 4) rise[nr] = k;
        nr++;
        check($sformatf("c_data%0d", k), 8'(data), 8'h05);
      end
      if (valid0 === 1'b1) begin
        if (nr0 < 4) rise0[nr0] = k;
        nr0++;
      end
    end
    check("c_count",  8'(nr),  8'd4);
    check("c0_count", 8'(nr0), 8'd8);
    if (nr >= 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("c_rise%0d", i), 8'(rise[i]), 8'(8 + 9 * i));
    end
    if (nr0 >= 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("c0_rise%0d", i), 8'(rise0[i]), 8'(4 + 5 * i));
    end
    // Throttle via ready.
    ready = 1'b0;
    tick(12);
    check("c_hold_valid", 8'(valid), 8'd1);
    check("c_hold_busy",  8'(busy),  8'd0);
    ready = 1'b1;
    tick(1);
    check("c_restart_valid", 8'(valid),    8'd0);
    check("c_restart_busy",  8'(busy),     8'd1);
    check("c_restart_sel",   8'({s2, s1}), 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
